// File: rtl/cla_pkg.sv
// ============================================================================
// cla_pkg : shared types and constants for the time-shared CLA adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice4.sv
// ============================================================================
// cla_slice4 : combinational 4-bit carry-lookahead adder slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products of generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder.sv
// ============================================================================
// cla_seq_adder : WIDTH-bit add/subtract, one 4-bit CLA slice per cycle, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int KW     = $clog2(NSLICE);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  assign accept  = in_valid && in_ready;
  assign last    = (k == K_LAST);
  assign slice_a = a_q[SLICE_W*k +: SLICE_W];
  assign slice_b = b_q[SLICE_W*k +: SLICE_W];

  cla_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Subtraction is A + ~B + 1, so B is inverted and the carry forced at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b ^ {WIDTH{in_sub}};
        carry <= in_sub ? 1'b1 : in_cin;
        k     <= '0;
      end else if (state == RUN) begin
        sum_q[SLICE_W*k +: SLICE_W] <= slice_sum;
        carry <= slice_cout;
        k     <= k + 1'b1;
        if (last) begin
          cout_q <= slice_cout;
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
// ============================================================================
// tb_cla_seq_adder : directed self-checking bench for cla_seq_adder (WIDTH=16)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int total  = 0;
  int passed = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] esum, input logic ecout, input logic eovf);
    int n;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    launch(a, b, cin, sub);
    wait_valid(n);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(out_sum), 32'(esum));
    check({tag, "_cout"}, 32'(out_cout), 32'(ecout));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(eovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_flags", 32'({out_cout, out_ovf}), 32'd0);

    run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_cin_ign", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Backpressure: a new request waits while the finished result is held.
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd4);
    in_a     = 16'h0100;
    in_b     = 16'h0200;
    in_sub   = 1'b0;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(out_sum), 32'h3333);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    check("bp_accept_ready", 32'(in_ready), 32'd0);
    wait_valid(n);
    check("bp_new_latency", 32'(n), 32'd4);
    check("bp_new_sum", 32'(out_sum), 32'h0300);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort in mid-run with part of the result already written.
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(out_sum), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    run_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
